// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus shared by the requesters, the tx arbiter and the UART serializer.
// timeout_pulse exists only when UART_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_valid;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_ready;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic                    timeout_pulse;
`endif

    // Requesters and serializer side.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, busy
`ifdef UART_ARB_TIMEOUT_EN
        , input timeout_pulse
`endif
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, busy
`ifdef UART_ARB_TIMEOUT_EN
        , output timeout_pulse
`endif
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte transmitter among N_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to force release of an owner that stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 86800
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    if (N_REQ < 2 || N_REQ > 8 || DATA_W != 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 131072) begin : gBadParams
        $error("uart_tx_arbiter: illegal parameter set");
    end

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             anyValid;
    logic             transfer;
    logic             releaseNow;
    logic             timeoutHit;

    // Scan downward so the closest requester after rrPtr_q is the last one to win.
    always_comb begin
        winner   = rrPtr_q;
        anyValid = 1'b0;
        cand     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rrPtr_q) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                winner   = cand;
                anyValid = 1'b1;
            end
        end
    end

    always_comb begin
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        if (state_q == LOCKED) begin
            bus.req_ready[owner_q] = bus.tx_ready;
            if (bus.req_valid[owner_q]) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = bus.req_data[owner_q*DATA_W +: DATA_W];
            end
        end
    end

    assign transfer   = bus.tx_valid && bus.tx_ready;
    assign releaseNow = (state_q == LOCKED) && ((transfer && bus.req_last[owner_q]) || timeoutHit);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d         = LOCKED;
                    owner_d         = winner;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                end
            end
            LOCKED: begin
                if (releaseNow) begin
                    state_d = IDLE;
                    rrPtr_d = owner_q;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rrPtr_q <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == LOCKED);

`ifdef UART_ARB_TIMEOUT_EN
    logic [16:0] idleCnt_q, idleCnt_d;
    logic        timeoutPulse_q;

    // Counts locked cycles without a transfer; it is zero whenever a grant starts.
    assign timeoutHit = (state_q == LOCKED) && !transfer && (idleCnt_q == 17'(TIMEOUT_CYCLES - 1));
    assign idleCnt_d  = (state_q != LOCKED || transfer) ? 17'd0 : idleCnt_q + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt_q      <= '0;
            timeoutPulse_q <= 1'b0;
        end else begin
            idleCnt_q      <= idleCnt_d;
            timeoutPulse_q <= timeoutHit;
        end
    end

    assign bus.timeout_pulse = timeoutPulse_q;
`else
    assign timeoutHit = 1'b0;
`endif
endmodule
